// File: rtl/serial_word_compare_sequencer.sv
// -----------------------------------------------------------------------------
// serial_word_compare_sequencer
//
// Front/back end for an MSB-first serial comparator FSM. Accepts a pair of
// parallel WIDTH-bit words, shifts them out MSB-first one bit per clock, holds
// the comparator in reset between words, and captures the comparator's final
// verdict on the LSB cycle into a one-deep result register.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its data stable
// until the transfer. in_ready may depend on res_ready (combinational path).
//
// Ports
//   clk          in   1      clock, all logic on posedge
//   rst          in   1      synchronous reset, active-low
//   in_valid     in   1      word pair available
//   in_ready     out  1      pair accepted this cycle (with in_valid)
//   in_a, in_b   in   WIDTH  operands, sampled only on the accept cycle
//   ser_a/ser_b  out  1      current serial bit of A/B, MSB first
//   ser_valid    out  1      ser_a/ser_b carry a live bit
//   ser_last     out  1      current bit is the LSB
//   cmp_clear    out  1      comparator sync reset, active-high
//   cmp_less/eq/greater in 1 combinational comparator verdict
//   res_valid    out  1      result held
//   res_ready    in   1      consumer takes result
//   res_less/eq/greater out 1 captured verdict
// -----------------------------------------------------------------------------
module serial_word_compare_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             cmp_clear,
   input  logic             cmp_less,
   input  logic             cmp_eq,
   input  logic             cmp_greater,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_less,
   output logic             res_eq,
   output logic             res_greater
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic             in_shift;
   logic             accept;

   assign in_shift = (state == SHIFT);

   // The result slot must be empty (or draining this cycle) before a new
   // word starts, so a capture can never overwrite an undrained result.
   assign in_ready = rst && !in_shift && (!res_valid || res_ready);
   assign accept   = in_valid && in_ready;

   assign ser_valid = in_shift;
   assign ser_a     = in_shift && shift_a[WIDTH-1];
   assign ser_b     = in_shift && shift_b[WIDTH-1];
   assign ser_last  = in_shift && (bit_cnt == '0);

   // Clearing on the LSB cycle (and throughout IDLE) leaves the comparator
   // in its equal state for the first bit of the next word. The comparator
   // outputs are combinational, so the clear does not disturb the verdict
   // being captured on the LSB cycle.
   assign cmp_clear = !rst || !in_shift || ser_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shift_a <= '0;
         shift_b <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shift_a <= in_a;
                  shift_b <= in_b;
                  bit_cnt <= CW'(WIDTH - 1);
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               shift_a <= {shift_a[WIDTH-2:0], 1'b0};
               shift_b <= {shift_b[WIDTH-2:0], 1'b0};
               bit_cnt <= bit_cnt - CW'(1);
               if (ser_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Capture wins over drain; the accept rule makes a collision impossible
   // in practice, but the priority keeps the result from being lost.
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_valid   <= 1'b0;
         res_less    <= 1'b0;
         res_eq      <= 1'b0;
         res_greater <= 1'b0;
      end else if (ser_last) begin
         res_valid   <= 1'b1;
         res_less    <= cmp_less;
         res_eq      <= cmp_eq;
         res_greater <= cmp_greater;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_word_compare_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for serial_word_compare_sequencer (WIDTH=8), with a behavioural
// MSB-first serial comparator attached to the ser_* / cmp_* ports.
// -----------------------------------------------------------------------------
module tb_serial_word_compare_sequencer;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         ser_a, ser_b, ser_valid, ser_last, cmp_clear;
   logic         cmp_less, cmp_eq, cmp_greater;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic         res_less, res_eq, res_greater;

   serial_word_compare_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .ser_a       (ser_a),
      .ser_b       (ser_b),
      .ser_valid   (ser_valid),
      .ser_last    (ser_last),
      .cmp_clear   (cmp_clear),
      .cmp_less    (cmp_less),
      .cmp_eq      (cmp_eq),
      .cmp_greater (cmp_greater),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_less    (res_less),
      .res_eq      (res_eq),
      .res_greater (res_greater)
   );

   // ---------------- comparator model (Mealy, MSB first) ----------------
   // 0 = equal so far, 1 = A greater decided, 2 = A less decided
   logic [1:0] cmp_st = 2'd0;
   always @(posedge clk) begin
      if (cmp_clear)
         cmp_st <= 2'd0;
      else if (cmp_st == 2'd0 && ser_a != ser_b)
         cmp_st <= ser_a ? 2'd1 : 2'd2;
   end
   assign cmp_greater = (cmp_st == 2'd1) || (cmp_st == 2'd0 && ser_a && !ser_b);
   assign cmp_less    = (cmp_st == 2'd2) || (cmp_st == 2'd0 && !ser_a && ser_b);
   assign cmp_eq      = (cmp_st == 2'd0) && (ser_a == ser_b);

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [2:0]   exp_q[$];   // {less, eq, greater}
   int           acc_q[$];   // accept cycle of each word
   logic         trk = 1'b0;  // a word is being shifted
   int           bidx = 0;
   logic [W-1:0] word_a, word_b;
   logic         prev_rv = 1'b0;
   logic         tput_en = 1'b0;
   int           last_res = -1;

   always @(negedge clk) begin
      if (!rst) begin
         check_eq("rst_in_ready", in_ready, 0);
         check_eq("rst_cmp_clear", cmp_clear, 1);
         exp_q.delete();
         acc_q.delete();
         trk     = 1'b0;
         prev_rv = 1'b0;
      end else begin
         check_eq("in_ready", in_ready, !trk && (!res_valid || res_ready));
         check_eq("ser_valid", ser_valid, trk);
         if (trk) begin
            check_eq("ser_a", ser_a, word_a[bidx]);
            check_eq("ser_b", ser_b, word_b[bidx]);
            check_eq("ser_last", ser_last, bidx == 0);
            check_eq("cmp_clear_bit", cmp_clear, bidx == 0);
            if (bidx == 0) trk = 1'b0;
            else bidx--;
         end else begin
            check_eq("cmp_clear_idle", cmp_clear, 1);
         end

         if (in_valid && in_ready) begin
            exp_q.push_back({in_a < in_b, in_a == in_b, in_a > in_b});
            acc_q.push_back(cyc);
            word_a = in_a;
            word_b = in_b;
            bidx   = W - 1;
            trk    = 1'b1;
         end

         if (res_valid && !prev_rv) begin
            check_eq("acc_q_nonempty", acc_q.size() != 0, 1);
            if (acc_q.size() != 0) check_eq("latency", cyc - acc_q.pop_front(), W + 1);
            if (tput_en && last_res >= 0) check_eq("throughput", cyc - last_res, W + 1);
            last_res = cyc;
         end
         if (res_valid && res_ready) begin
            check_eq("exp_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
               check_eq("result", {res_less, res_eq, res_greater}, exp_q.pop_front());
         end
         prev_rv = res_valid;
      end
   end

   // ---------------- driver tasks ----------------
   // Presents a pair and returns just after the accepting edge; in_valid is
   // left high so back-to-back calls stream continuously.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int t = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check_eq("accept_timeout", t, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      in_valid = 1'b0;
      while ((exp_q.size() != 0 || trk) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain_pending", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [2:0] held;

   initial begin
      // reset
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_eq("post_rst_res_valid", res_valid, 0);
      check_eq("post_rst_res_bits", {res_less, res_eq, res_greater}, 0);
      check_eq("post_rst_ser_valid", ser_valid, 0);
      check_eq("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // 1..3: equal, MSB decides, LSB decides
      send(8'h5A, 8'h5A);
      drain();
      send(8'h80, 8'h7F);
      drain();
      send(8'h3C, 8'h3D);
      drain();

      // 4: result back-pressure with a second pair waiting
      res_ready = 1'b0;
      send(8'h10, 8'h20);
      in_a = 8'hC3;
      in_b = 8'hC3;
      begin
         int t = 0;
         @(negedge clk);
         while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
         check_eq("bp_res_valid", res_valid, 1);
      end
      held = {res_less, res_eq, res_greater};
      check_eq("bp_first_result", held, 3'b100);
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_in_ready_low", in_ready, 0);
         check_eq("bp_res_hold", {res_less, res_eq, res_greater}, held);
         check_eq("bp_res_valid_hold", res_valid, 1);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_accept_on_drain", in_ready, 1);
      @(posedge clk);
      #1;
      drain();

      // 5: reset on the 4th bit abandons the word
      send(8'h55, 8'h33);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_res_valid", res_valid, 0);
      check_eq("midrst_ser_valid", ser_valid, 0);
      check_eq("midrst_cmp_clear", cmp_clear, 1);
      @(posedge clk);
      #1;
      send(8'h01, 8'h02);
      drain();

      // 6: continuous stream of random pairs
      tput_en  = 1'b1;
      last_res = -1;
      for (int i = 0; i < 16; i++) begin
         logic [W-1:0] a, b;
         a = W'($urandom_range(0, 255));
         b = (i % 4 == 0) ? a : W'($urandom_range(0, 255));
         send(a, b);
      end
      drain();
      tput_en = 1'b0;

      check_eq("final_exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
